rob_wb_arbiter: RTL and testbench



---
 rtl/rob_wb_arbiter_pkg.sv | 27 ++
 rtl/rob_wb_arbiter_rr_pick.sv | 40 ++++
 rtl/rob_wb_arbiter.sv | 116 +++++++++++
 tb/tb_rob_wb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types and constants for the ROB write-back arbiter.
// A tag of all ones marks an idle ROB write port.
package rob_wb_arbiter_pkg;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 32;

   localparam logic [TAG_W-1:0] TAG_INVALID = '1;

   typedef enum logic [2:0] {
      SRC_ALU = 3'd0,
      SRC_FWD = 3'd1,
      SRC_JMP = 3'd2,
      SRC_BR  = 3'd3,
      SRC_MEM = 3'd4
   } src_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] val;
      logic [DATA_W-1:0] npc;
      logic              has_npc;
   } wb_req_t;

   localparam wb_req_t WB_IDLE = '{tag: TAG_INVALID, val: '0, npc: '0, has_npc: 1'b0};

endpackage

// File: rtl/rob_wb_arbiter_rr_pick.sv
// Rotating-priority first-one finder: scans i_ptr, i_ptr+1, ... modulo N
// over the unmasked requests and returns a one-hot grant plus its index.
module rob_wb_arbiter_rr_pick #(
   parameter int N  = 5,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [N-1:0]  i_mask,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_found
);

   logic [N-1:0] w_req;

   assign w_req = i_req & ~i_mask;

   always_comb begin
      int            s;
      logic [PW-1:0] w_j;
      s       = 0;
      w_j     = '0;
      o_grant = '0;
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         // N need not be a power of two, so wrap explicitly
         s = int'(i_ptr) + k;
         if (s >= N) s = s - N;
         w_j = PW'(s);
         if (!o_found && w_req[w_j]) begin
            o_found      = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Completion-side arbiter: one holding register per producer, up to N_PORT
// round-robin grants per cycle onto registered ROB write ports.
module rob_wb_arbiter
   import rob_wb_arbiter_pkg::*;
#(
   parameter int N_SRC  = 5,
   parameter int N_PORT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [N_SRC-1:0]         src_valid,
   input  logic [N_SRC*TAG_W-1:0]   src_tag,
   input  logic [N_SRC*DATA_W-1:0]  src_val,
   input  logic [N_SRC*DATA_W-1:0]  src_npc,
   input  logic [N_SRC-1:0]         src_has_npc,
   output logic [N_SRC-1:0]         src_ready,
   output logic [N_PORT*TAG_W-1:0]  wr_tag,
   output logic [N_PORT*DATA_W-1:0] wr_val,
   output logic [N_PORT*DATA_W-1:0] wr_npc,
   output logic [N_PORT-1:0]        wr_has_npc,
   output logic [15:0]              conflict_cnt
);

   localparam int PW = $clog2(N_SRC);

   wb_req_t                        r_hold [N_SRC];
   logic [N_SRC-1:0]               r_hold_v;
   logic [PW-1:0]                  r_rr_ptr;
   logic [15:0]                    r_conflict_cnt;
   wb_req_t                        r_wr_p1 [N_PORT];

   logic [N_PORT:0][N_SRC-1:0]     w_mask;
   logic [N_PORT-1:0][N_SRC-1:0]   w_pgrant;
   logic [N_PORT-1:0][PW-1:0]      w_pidx;
   logic [N_PORT-1:0]              w_pfound;
   logic [N_SRC-1:0]               w_grant;
   logic [N_SRC-1:0]               w_accept;
   logic [PW-1:0]                  w_last;
   logic [PW-1:0]                  w_next_ptr;
   logic                           w_any;

   // Each picker sees the requests left over by the ports before it
   assign w_mask[0] = '0;
   for (genvar p = 0; p < N_PORT; p++) begin : g_pick
      rob_wb_arbiter_rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
         .i_req   (r_hold_v),
         .i_mask  (w_mask[p]),
         .i_ptr   (r_rr_ptr),
         .o_grant (w_pgrant[p]),
         .o_idx   (w_pidx[p]),
         .o_found (w_pfound[p])
      );
      assign w_mask[p+1] = w_mask[p] | w_pgrant[p];

      assign wr_tag[p*TAG_W +: TAG_W]    = r_wr_p1[p].tag;
      assign wr_val[p*DATA_W +: DATA_W]  = r_wr_p1[p].val;
      assign wr_npc[p*DATA_W +: DATA_W]  = r_wr_p1[p].npc;
      assign wr_has_npc[p]               = r_wr_p1[p].has_npc;
   end

   assign w_grant = w_mask[N_PORT];
   assign w_any   = |w_pfound;

   always_comb begin
      w_last = '0;
      for (int p = 0; p < N_PORT; p++) begin
         if (w_pfound[p]) w_last = w_pidx[p];
      end
      w_next_ptr = (w_last == PW'(N_SRC - 1)) ? '0 : w_last + PW'(1);
   end

   // A granted slot frees this edge, so the producer may refill it at once
   assign src_ready    = {N_SRC{~rst & ~flush}} & (~r_hold_v | w_grant);
   assign w_accept     = src_valid & src_ready;
   assign conflict_cnt = r_conflict_cnt;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (w_accept[i]) begin
            r_hold[i] <= '{tag:     src_tag[i*TAG_W +: TAG_W],
                           val:     src_val[i*DATA_W +: DATA_W],
                           npc:     src_npc[i*DATA_W +: DATA_W],
                           has_npc: src_has_npc[i]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_v       <= '0;
         r_rr_ptr       <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (($countones(r_hold_v) > N_PORT) && (r_conflict_cnt != 16'hFFFF))
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         if (flush) begin
            r_hold_v <= '0;
         end else begin
            r_hold_v <= (r_hold_v & ~w_grant) | w_accept;
            if (w_any) r_rr_ptr <= w_next_ptr;
         end
      end
   end

   // A protocol-error tag still consumes its grant but leaves the port idle
   always_ff @(posedge clk) begin
      for (int p = 0; p < N_PORT; p++) begin
         if (rst || flush || !w_pfound[p] || (r_hold[w_pidx[p]].tag == TAG_INVALID))
            r_wr_p1[p] <= WB_IDLE;
         else
            r_wr_p1[p] <= r_hold[w_pidx[p]];
      end
   end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter with hand-computed expectations.
module tb_rob_wb_arbiter;
   import rob_wb_arbiter_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [4:0]    src_valid;
   logic [19:0]   src_tag;
   logic [159:0]  src_val;
   logic [159:0]  src_npc;
   logic [4:0]    src_has_npc;
   logic [4:0]    src_ready;
   logic [7:0]    wr_tag;
   logic [63:0]   wr_val;
   logic [63:0]   wr_npc;
   logic [1:0]    wr_has_npc;
   logic [15:0]   conflict_cnt;

   int n_run  = 0;
   int n_fail = 0;

   rob_wb_arbiter #(.N_SRC(5), .N_PORT(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .src_valid    (src_valid),
      .src_tag      (src_tag),
      .src_val      (src_val),
      .src_npc      (src_npc),
      .src_has_npc  (src_has_npc),
      .src_ready    (src_ready),
      .wr_tag       (wr_tag),
      .wr_val       (wr_val),
      .wr_npc       (wr_npc),
      .wr_has_npc   (wr_has_npc),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      src_valid   = '0;
      src_tag     = '0;
      src_val     = '0;
      src_npc     = '0;
      src_has_npc = '0;
   endtask

   task automatic set_src(input int i, input int t, input logic [31:0] v,
                          input logic [31:0] n, input int h);
      src_valid[i]        = 1'b1;
      src_tag[i*4 +: 4]   = 4'(t);
      src_val[i*32 +: 32] = v;
      src_npc[i*32 +: 32] = n;
      src_has_npc[i]      = (h != 0);
   endtask

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
      n_run++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp_v);
      end
   endtask

   task automatic chk_port(input string nm, input int p, input int t, input logic [31:0] v);
      chk({nm, ".tag"}, 32'(wr_tag[p*4 +: 4]), 32'(t));
      chk({nm, ".val"}, wr_val[p*32 +: 32], v);
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      clr();
      step();
      step();
      chk_port("rst.p0", 0, 15, 32'h0);
      chk_port("rst.p1", 1, 15, 32'h0);
      chk("rst.npc", wr_npc[31:0], 32'h0);
      chk("rst.cnt", 32'(conflict_cnt), 32'h0);
      chk("rst.ready", 32'(src_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst.ready", 32'(src_ready), 32'h1f);

      // alu alone: visible two edges after the handshake
      set_src(int'(SRC_ALU), 3, 32'h1234, 32'h0, 0);
      step();
      clr();
      #1;
      chk("alu.ready", 32'(src_ready[0]), 32'h1);
      chk_port("alu.early", 0, 15, 32'h0);
      step();
      chk_port("alu.p0", 0, 3, 32'h1234);
      chk_port("alu.p1", 1, 15, 32'h0);
      chk("alu.has", 32'(wr_has_npc[0]), 32'h0);
      step();
      chk_port("alu.after", 0, 15, 32'h0);

      // branch with next_pc
      set_src(int'(SRC_BR), 7, 32'h1, 32'h40, 1);
      step();
      clr();
      step();
      chk_port("br.p0", 0, 7, 32'h1);
      chk("br.npc", wr_npc[31:0], 32'h40);
      chk("br.has", 32'(wr_has_npc[0]), 32'h1);
      chk_port("br.p1", 1, 15, 32'h0);
      step();

      // reset returns rr_ptr to 0
      rst = 1'b1;
      step();
      rst = 1'b0;

      // all five at once
      for (int i = 0; i < 5; i++) set_src(i, i, 32'(32'h100 + i), 32'h0, 0);
      step();
      clr();
      step();
      chk_port("five.c1.p0", 0, 0, 32'h100);
      chk_port("five.c1.p1", 1, 1, 32'h101);
      chk("five.c1.cnt", 32'(conflict_cnt), 32'd1);
      step();
      chk_port("five.c2.p0", 0, 2, 32'h102);
      chk_port("five.c2.p1", 1, 3, 32'h103);
      chk("five.c2.cnt", 32'(conflict_cnt), 32'd2);
      step();
      chk_port("five.c3.p0", 0, 4, 32'h104);
      chk_port("five.c3.p1", 1, 15, 32'h0);
      chk("five.c3.cnt", 32'(conflict_cnt), 32'd2);

      // forwarder alone moves rr_ptr to 2
      set_src(int'(SRC_FWD), 9, 32'h99, 32'h0, 0);
      step();
      clr();
      step();
      chk_port("fwd.p0", 0, 9, 32'h99);
      step();

      // sources 1 and 4 streaming back to back
      set_src(1, 5, 32'h1000, 32'h0, 0);
      set_src(4, 6, 32'h2000, 32'h0, 0);
      step();
      for (int k = 1; k < 5; k++) begin
         set_src(1, 5, 32'(32'h1000 + k), 32'h0, 0);
         set_src(4, 6, 32'(32'h2000 + k), 32'h0, 0);
         #1;
         chk("cont.ready", 32'(src_ready & 5'h12), 32'h12);
         step();
         chk_port("cont.p0", 0, 6, 32'(32'h2000 + k - 1));
         chk_port("cont.p1", 1, 5, 32'(32'h1000 + k - 1));
      end
      clr();
      step();
      chk_port("cont.last.p0", 0, 6, 32'h2004);
      chk_port("cont.last.p1", 1, 5, 32'h1004);
      step();

      // flush with five held
      for (int i = 0; i < 5; i++) set_src(i, 10 + i, 32'(32'h300 + i), 32'h0, 0);
      step();
      flush = 1'b1;
      for (int i = 0; i < 5; i++) set_src(i, i, 32'(32'h400 + i), 32'h0, 0);
      #1;
      chk("flush.ready", 32'(src_ready), 32'h0);
      step();
      chk_port("flush.p0", 0, 15, 32'h0);
      chk_port("flush.p1", 1, 15, 32'h0);
      chk("flush.cnt", 32'(conflict_cnt), 32'd3);
      flush = 1'b0;
      clr();
      step();
      chk_port("flush.drop.p0", 0, 15, 32'h0);
      chk_port("flush.drop.p1", 1, 15, 32'h0);
      for (int i = 0; i < 5; i++) set_src(i, i, 32'(32'h500 + i), 32'h0, 0);
      step();
      clr();
      step();
      chk_port("ptr.c1.p0", 0, 2, 32'h502);
      chk_port("ptr.c1.p1", 1, 3, 32'h503);
      chk("ptr.c1.cnt", 32'(conflict_cnt), 32'd4);
      step();
      chk_port("ptr.c2.p0", 0, 4, 32'h504);
      chk_port("ptr.c2.p1", 1, 0, 32'h500);
      chk("ptr.c2.cnt", 32'(conflict_cnt), 32'd5);
      step();
      chk_port("ptr.c3.p0", 0, 1, 32'h501);
      chk_port("ptr.c3.p1", 1, 15, 32'h0);

      // keep all holds full until the counter reaches 9, then reset
      for (int i = 0; i < 5; i++) set_src(i, i, 32'(32'h600 + i), 32'h0, 0);
      step();
      for (int k = 0; k < 4; k++) step();
      chk("full.cnt", 32'(conflict_cnt), 32'd9);
      chk("full.ready", 32'($countones(src_ready)), 32'd2);
      rst = 1'b1;
      #1;
      chk("rst2.ready", 32'(src_ready), 32'h0);
      step();
      chk_port("rst2.p0", 0, 15, 32'h0);
      chk_port("rst2.p1", 1, 15, 32'h0);
      chk("rst2.cnt", 32'(conflict_cnt), 32'h0);
      chk("rst2.has", 32'(wr_has_npc), 32'h0);
      rst = 1'b0;
      clr();
      #1;
      chk("rst2.ready_after", 32'(src_ready), 32'h1f);
      step();
      chk_port("rst2.drop.p0", 0, 15, 32'h0);

      // invalid producer tag consumes port 0 but leaves it idle
      set_src(0, 15, 32'h5, 32'h0, 0);
      set_src(2, 8, 32'h88, 32'h0, 0);
      step();
      clr();
      step();
      chk_port("inv.p0", 0, 15, 32'h0);
      chk_port("inv.p1", 1, 8, 32'h88);
      step();
      chk_port("inv.after.p0", 0, 15, 32'h0);
      chk_port("inv.after.p1", 1, 15, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
